// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state type and default width for the serial subtractor
package serial_arith_pkg;
  localparam int SERIAL_WIDTH_DEF = 6;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: one-bit full subtractor cell (d = a - b - bin)
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first; OVF output when SERIAL_SUBTRACTOR_OVF_EN is defined
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             OVF
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, borrow_q, borrow_d;
  logic d_bit, bout, accept, last;
  assign accept = start && (state_q != SHIFT);
  assign last = cnt_q == CW'(WIDTH - 1);
  full_subtractor_bit u_fsb (.a(a_q[0]), .b(b_q[0]), .bin(br_q), .d(d_bit), .bout(bout));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    diff_d = diff_q;
    cnt_d = cnt_q;
    br_d = br_q;
    borrow_d = borrow_q;
    if (accept) begin
      state_d = SHIFT;
      a_d = A;
      b_d = B;
      br_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      res_d = {d_bit, res_q[WIDTH-1:1]};
      br_d = bout;
      cnt_d = cnt_q + 1'b1;
      state_d = last ? DONE : SHIFT;
      diff_d = last ? res_d : diff_q;
      borrow_d = last ? bout : borrow_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      diff_q <= '0;
      cnt_q <= '0;
      br_q <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      diff_q <= diff_d;
      cnt_q <= cnt_d;
      br_q <= br_d;
      borrow_q <= borrow_d;
    end
  end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // operand MSBs are kept aside because the shift registers lose them
  logic am_q, bm_q, ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_q <= 1'b0;
      bm_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      am_q <= accept ? A[WIDTH-1] : am_q;
      bm_q <= accept ? B[WIDTH-1] : bm_q;
      ovf_q <= (!accept && state_q == SHIFT && last) ? ((am_q != bm_q) && (d_bit != am_q)) : ovf_q;
    end
  end
  assign OVF = ovf_q;
`endif
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign DIFF = diff_q;
  assign BORROW = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors against a cycle-level arithmetic model
module tb_serial_subtractor;
  localparam int W = 6;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] A = 0, B = 0, DIFF;
  logic busy, done, BORROW;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic OVF;
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .DIFF(DIFF), .BORROW(BORROW), .OVF(OVF));
`else
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .DIFF(DIFF), .BORROW(BORROW));
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: an accepted operation finishes WIDTH cycles later with plain A-B
  logic [W-1:0] sub_ab;
  assign sub_ab = A - B;
  int m_rem;
  logic m_done, m_borrow, m_pb, m_ovf, m_po;
  logic [W-1:0] m_diff, m_pd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_done <= 0; m_diff <= 0; m_borrow <= 0; m_ovf <= 0;
    end else begin
      if (m_rem == 1) begin
        m_diff <= m_pd; m_borrow <= m_pb; m_ovf <= m_po;
      end
      m_done <= (m_rem == 1);
      if (start && m_rem == 0) begin
        m_rem <= W;
        m_pd <= sub_ab;
        m_pb <= A < B;
        m_po <= (A[W-1] != B[W-1]) && (sub_ab[W-1] != A[W-1]);
      end else if (m_rem > 0) m_rem <= m_rem - 1;
    end
  end
  always @(negedge clk) begin
    chk("busy", busy, m_rem > 0);
    chk("done", done, m_done);
    chk("DIFF", DIFF, m_diff);
    chk("BORROW", BORROW, m_borrow);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("OVF", OVF, m_ovf);
`endif
  end
  // Pulse start for one cycle, then count cycles to done (expect busy 6, done in the 7th)
  task automatic run(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ed, input logic eb);
    int n, nb;
    @(negedge clk); start = 1; A = a; B = b;
    @(negedge clk); start = 0;
    n = 1; nb = 0;
    while (!done && n < 20) begin
      nb += busy;
      @(negedge clk); n++;
    end
    chk({nm, "_lat"}, n, W + 1);
    chk({nm, "_busycyc"}, nb, W);
    chk({nm, "_diff"}, DIFF, ed);
    chk({nm, "_borrow"}, BORROW, eb);
  endtask
  initial begin
    int n, nd;
    #12;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_diff", DIFF, 0); chk("rst_borrow", BORROW, 0);
    @(negedge clk); rst_n = 1;
    run("t48m33", 6'd48, 6'd33, 6'b001111, 0);
    run("t15m33", 6'd15, 6'd33, 6'd46, 1);
    run("t0m1", 6'd0, 6'd1, 6'b111111, 1);
    run("t33m33", 6'd33, 6'd33, 6'd0, 0);
    run("t63m0", 6'd63, 6'd0, 6'd63, 0);
    run("t1m63", 6'd1, 6'd63, 6'd2, 1);
    run("t32m1", 6'd32, 6'd1, 6'b011111, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("t32m1_ovf", OVF, 1);
    run("t48m33b", 6'd48, 6'd33, 6'd15, 0);
    chk("t48m33_ovf", OVF, 0);
`endif
    // start re-pulsed during SHIFT must be ignored
    @(negedge clk); start = 1; A = 20; B = 5;
    @(negedge clk); start = 0;
    @(negedge clk); @(negedge clk); start = 1; A = 1; B = 60;
    @(negedge clk); start = 0;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("ign_done_seen", done, 1);
    chk("ign_diff", DIFF, 15);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nd += done;
      chk("ign_hold", DIFF, 15);
    end
    chk("ign_single_done", nd, 0);
    // back-to-back: start held through the done cycle
    @(negedge clk); start = 1; A = 48; B = 33;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    chk("b2b_first_diff", DIFF, 15);
    A = 10; B = 3;
    @(negedge clk); start = 0;
    n = 1;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("b2b_gap", n, W + 1);
    chk("b2b_diff", DIFF, 7);
    run("t0m1b", 6'd0, 6'd1, 6'd63, 1);
    // asynchronous abort in the 3rd SHIFT cycle
    @(negedge clk); start = 1; A = 48; B = 33;
    @(negedge clk); start = 0;
    @(posedge clk); @(posedge clk); #2 rst_n = 0;
    #1;
    chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    chk("abort_diff", DIFF, 0); chk("abort_borrow", BORROW, 0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); nd += done; end
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); nd += done; end
    chk("abort_no_done", nd, 0);
    run("t5m9", 6'd5, 6'd9, 6'd60, 1);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
